// File: rtl/eqed_inject_ctrl.sv
// eqed_inject_ctrl: E-QED single-cycle bit-flip injection sequencer.
// Holds the DUT in reset and then releases it. Fires a one-hot eqed_sel on the
// chosen cycle, times the MISR capture window and reports detection.
// Optional feature: define EQED_INJECT_SWEEP_EN to sweep (ff index, cycle)
// pairs back-to-back up to cyc_max. Without it, each start makes one run.
module eqed_inject_ctrl #(
  parameter int unsigned N_FF   = 8,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned CYC_W  = 10,
  parameter int unsigned WINDOW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] ff_idx,
  input  logic [CYC_W-1:0] inj_cyc,
  input  logic [CYC_W-1:0] cyc_max,
  input  logic             misr_ok,
  output logic             busy,
  output logic             dut_rst,
  output logic [N_FF-1:0]  eqed_sel,
  output logic             error_injected,
  output logic [CYC_W-1:0] cycle_count,
  output logic             capture,
  output logic [SEL_W-1:0] cur_idx,
  output logic [CYC_W-1:0] cur_cyc,
  output logic             done,
  output logic             detected,
  output logic             last
);

  localparam int unsigned      WIN_W    = $clog2(WINDOW + 1);
  localparam int unsigned      CYC_XW   = CYC_W + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SEL_W-1:0] IDX_LIM  = SEL_W'(N_FF);
  localparam logic [SEL_W-1:0] IDX_TOP  = SEL_W'(N_FF - 1);
  localparam logic [CYC_W-1:0] CYC_SAT  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_RUN,
    S_CAPT,
    S_REPORT
  } state_t;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic [CYC_W-1:0] cnt_nxt, cnt_inc;
  logic [SEL_W-1:0] idx_nxt, idx_adv;
  logic [CYC_W-1:0] cyc_nxt, cyc_adv;
  logic             err_nxt, done_nxt, det_nxt, last_nxt;
  logic             busy_nxt, dut_rst_nxt, capture_nxt;
  logic             inject_c, run_end_c, final_run;

  // Injection fires for one RUN cycle when the counter hits the target cycle
  assign inject_c  = (state == S_RUN) && (cycle_count == cur_cyc) &&
                     (cur_cyc != '0) && (cur_idx < IDX_LIM);
  assign eqed_sel  = inject_c ? (N_FF'(1) << cur_idx) : '0;
  // RUN ends on the target cycle, after cycle 1 for a zero target, or on saturation
  assign run_end_c = (cycle_count == cur_cyc) ||
                     ((cur_cyc == '0) && (cycle_count == CYC_W'(1))) ||
                     (cycle_count == CYC_SAT);
  assign cnt_inc   = (cycle_count == CYC_SAT) ? cycle_count
                                              : cycle_count + CYC_W'(1);

`ifdef EQED_INJECT_SWEEP_EN
  logic [CYC_W-1:0]  cyc_lim;
  logic [CYC_XW-1:0] cyc_adv_x;

  // Next sweep point; a golden preamble index restarts at FF 0 on the same cycle
  always_comb begin
    idx_adv   = cur_idx + SEL_W'(1);
    cyc_adv_x = {1'b0, cur_cyc};
    if (cur_idx >= IDX_LIM) begin
      idx_adv = '0;
    end else if (cur_idx == IDX_TOP) begin
      idx_adv   = '0;
      cyc_adv_x = {1'b0, cur_cyc} + CYC_XW'(1);
    end
  end

  assign cyc_adv   = cyc_adv_x[CYC_W-1:0];
  assign final_run = cyc_adv_x > {1'b0, cyc_lim};

  // Sweep limit captured at start so the campaign bound cannot move mid-sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_lim <= '0;
    end else if ((state == S_IDLE) && start) begin
      cyc_lim <= cyc_max;
    end
  end
`else
  logic unused_cyc_max;

  assign idx_adv        = cur_idx;
  assign cyc_adv        = cur_cyc;
  assign final_run      = 1'b1;
  assign unused_cyc_max = ^cyc_max;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt;
    cnt_nxt   = cycle_count;
    idx_nxt   = cur_idx;
    cyc_nxt   = cur_cyc;
    err_nxt   = error_injected;
    done_nxt  = 1'b0;
    det_nxt   = 1'b0;
    last_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt   = ff_idx;
          cyc_nxt   = inj_cyc;
          state_nxt = S_DRST;
        end
      end
      S_DRST: begin
        err_nxt   = 1'b0;
        cnt_nxt   = CYC_W'(1);
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt_inc;
        if (inject_c) begin
          err_nxt = 1'b1;
        end
        if (run_end_c) begin
          win_nxt   = '0;
          state_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        cnt_nxt = cnt_inc;
        win_nxt = win_cnt + WIN_W'(1);
        if (win_cnt == WIN_LAST) begin
          done_nxt  = 1'b1;
          det_nxt   = ~misr_ok;
          last_nxt  = final_run;
          state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        if (last) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx_adv;
          cyc_nxt   = cyc_adv;
          state_nxt = S_DRST;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt    = (state_nxt != S_IDLE);
    dut_rst_nxt = !((state_nxt == S_RUN) || (state_nxt == S_CAPT));
    capture_nxt = (state_nxt == S_CAPT);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      win_cnt        <= '0;
      cycle_count    <= '0;
      cur_idx        <= '0;
      cur_cyc        <= '0;
      error_injected <= 1'b0;
      done           <= 1'b0;
      detected       <= 1'b0;
      last           <= 1'b0;
      busy           <= 1'b0;
      dut_rst        <= 1'b1;
      capture        <= 1'b0;
    end else begin
      state          <= state_nxt;
      win_cnt        <= win_nxt;
      cycle_count    <= cnt_nxt;
      cur_idx        <= idx_nxt;
      cur_cyc        <= cyc_nxt;
      error_injected <= err_nxt;
      done           <= done_nxt;
      detected       <= det_nxt;
      last           <= last_nxt;
      busy           <= busy_nxt;
      dut_rst        <= dut_rst_nxt;
      capture        <= capture_nxt;
    end
  end

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Testbench for eqed_inject_ctrl in the default single-run build.
module tb_eqed_inject_ctrl;

  localparam int unsigned N_FF   = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CYC_W  = 10;
  localparam int unsigned WINDOW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SEL_W-1:0] ff_idx;
  logic [CYC_W-1:0] inj_cyc;
  logic [CYC_W-1:0] cyc_max;
  logic             misr_ok;
  logic             busy;
  logic             dut_rst;
  logic [N_FF-1:0]  eqed_sel;
  logic             error_injected;
  logic [CYC_W-1:0] cycle_count;
  logic             capture;
  logic [SEL_W-1:0] cur_idx;
  logic [CYC_W-1:0] cur_cyc;
  logic             done;
  logic             detected;
  logic             last;

  int checks = 0;
  int errors = 0;

  eqed_inject_ctrl #(
    .N_FF  (N_FF),
    .SEL_W (SEL_W),
    .CYC_W (CYC_W),
    .WINDOW(WINDOW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ff_idx        (ff_idx),
    .inj_cyc       (inj_cyc),
    .cyc_max       (cyc_max),
    .misr_ok       (misr_ok),
    .busy          (busy),
    .dut_rst       (dut_rst),
    .eqed_sel      (eqed_sel),
    .error_injected(error_injected),
    .cycle_count   (cycle_count),
    .capture       (capture),
    .cur_idx       (cur_idx),
    .cur_cyc       (cur_cyc),
    .done          (done),
    .detected      (detected),
    .last          (last)
  );

  always #5 clk = ~clk;

  // One directed run: inputs plus hand-computed expectations.
  // Cycle numbers count from the edge that samples start (cycle 1 = DRST).
  typedef struct {
    logic [SEL_W-1:0] idx;
    logic [CYC_W-1:0] cyc;
    int               low_cyc;
    logic [N_FF-1:0]  exp_sel;
    logic             exp_err;
    logic             exp_det;
    int               exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int eff;
    string tag;
    tag = $sformatf("v%0d", n);
    eff = (v.cyc == '0) ? 1 : int'(v.cyc);
    ff_idx  = v.idx;
    inj_cyc = v.cyc;
    misr_ok = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      check({tag, "/sel"}, 32'(eqed_sel), (c == 1 + int'(v.cyc)) ? 32'(v.exp_sel) : 32'd0);
      check({tag, "/capture"}, 32'(capture), 32'((c >= 2 + eff) && (c <= 1 + eff + int'(WINDOW))));
      check({tag, "/done"}, 32'(done), 32'(c == v.exp_done));
      check({tag, "/busy"}, 32'(busy), 32'(c <= v.exp_done));
      check({tag, "/dut_rst"}, 32'(dut_rst), 32'(!((c >= 2) && (c < v.exp_done))));
      if (c >= 2) begin
        check({tag, "/err"}, 32'(error_injected), 32'(v.exp_err && (c >= 2 + int'(v.cyc))));
      end
      if ((c >= 2) && (c <= v.exp_done)) begin
        check({tag, "/count"}, 32'(cycle_count), 32'(c - 1));
      end
      if (c == 2) begin
        check({tag, "/cur_idx"}, 32'(cur_idx), 32'(v.idx));
        check({tag, "/cur_cyc"}, 32'(cur_cyc), 32'(v.cyc));
      end
      if (c == v.exp_done) begin
        check({tag, "/detected"}, 32'(detected), 32'(v.exp_det));
        check({tag, "/last"}, 32'(last), 32'd1);
      end
      misr_ok = (c != v.low_cyc);
      tick();
    end
    misr_ok = 1'b1;
  endtask

  initial begin
    int seen;
    int c;

    //          idx    cyc    low  exp_sel        err   det   done
    vecs[0] = '{4'd5,  10'd4,  -1, 8'b0010_0000, 1'b1, 1'b0, 11};
    vecs[1] = '{4'd8,  10'd3,  -1, 8'b0000_0000, 1'b0, 1'b0, 10};
    vecs[2] = '{4'd2,  10'd3,   9, 8'b0000_0100, 1'b1, 1'b1, 10};
    vecs[3] = '{4'd2,  10'd3,   8, 8'b0000_0100, 1'b1, 1'b0, 10};
    vecs[4] = '{4'd0,  10'd0,  -1, 8'b0000_0000, 1'b0, 1'b0,  8};
    vecs[5] = '{4'd7,  10'd1,   7, 8'b1000_0000, 1'b1, 1'b1,  8};
    vecs[6] = '{4'd15, 10'd2,   8, 8'b0000_0000, 1'b0, 1'b1,  9};
    vecs[7] = '{4'd1,  10'd20, -1, 8'b0000_0010, 1'b1, 1'b0, 27};

    rst     = 1'b1;
    start   = 1'b0;
    ff_idx  = '0;
    inj_cyc = '0;
    cyc_max = '0;
    misr_ok = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst/busy", 32'(busy), 32'd0);
    check("rst/dut_rst", 32'(dut_rst), 32'd1);
    check("rst/sel", 32'(eqed_sel), 32'd0);
    check("rst/err", 32'(error_injected), 32'd0);
    check("rst/count", 32'(cycle_count), 32'd0);
    check("rst/capture", 32'(capture), 32'd0);
    check("rst/cur_idx", 32'(cur_idx), 32'd0);
    check("rst/cur_cyc", 32'(cur_cyc), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/detected", 32'(detected), 32'd0);
    check("rst/last", 32'(last), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset during CAPT: idx 3, cyc 2 has CAPT on cycles 4..8
    ff_idx  = 4'd3;
    inj_cyc = 10'd2;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (4) tick();
    check("mid/capture_before", 32'(capture), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid/busy", 32'(busy), 32'd0);
    check("mid/dut_rst", 32'(dut_rst), 32'd1);
    check("mid/capture", 32'(capture), 32'd0);
    check("mid/done", 32'(done), 32'd0);
    check("mid/cur_idx", 32'(cur_idx), 32'd0);
    check("mid/err", 32'(error_injected), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("mid/no_done_after", 32'(seen), 32'd0);
    run_vec(vecs[0], 10);

    // start while busy must not reload the run parameters
    ff_idx  = 4'd5;
    inj_cyc = 10'd4;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    ff_idx  = 4'd1;
    inj_cyc = 10'd9;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    c = 4;
    check("busy/cur_idx", 32'(cur_idx), 32'd5);
    check("busy/cur_cyc", 32'(cur_cyc), 32'd4);
    while (!done && c < 60) begin
      tick();
      c++;
    end
    check("busy/done_cycle", 32'(c), 32'd11);
    check("busy/cur_idx_end", 32'(cur_idx), 32'd5);
    tick();
    check("busy/idle_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eqed_inject_ctrl.md
# eqed_inject_ctrl

Sequencer for single-cycle flip-flop bit-flip injection in E-QED campaigns. It holds the design under test (DUT) in reset, then releases it. It drives a one-hot `eqed_sel` vector into the DUT's inverting injection muxes for exactly one chosen cycle, then times the MISR capture window. At the end of the window it samples the MISR-compare result and reports it. It sits in the E-QED wrapper in place of the free-running decoder, so campaigns run in simulation as well as under formal.

## Interface
- `N_FF`, 8: number of injectable FFs, i.e. the width of `eqed_sel`.
- `SEL_W`, 4: width of the FF index. Must satisfy 2^SEL_W > N_FF so the "no injection" index exists.
- `CYC_W`, 10: width of the cycle counter and cycle operands.
- `WINDOW`, 5: capture window length in cycles. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  campaign start; sampled only in IDLE.
- `ff_idx`  in  SEL_W  first FF index. Any value ≥N_FF means a golden (no-injection) run.
- `inj_cyc`  in  CYC_W  first injection cycle. 0 means a golden run.
- `cyc_max`  in  CYC_W  last injection cycle swept; used only in sweep mode.
- `misr_ok`  in  1  1 when the input and output MISRs match the expected signatures.
- `busy`  out  1  high in every state except IDLE.
- `dut_rst`  out  1  reset to the DUT.
- `eqed_sel`  out  N_FF  one-hot injection select (combinational).
- `error_injected`  out  1  sticky; set once a flip has been applied in the current run.
- `cycle_count`  out  CYC_W  DUT cycle number, 1 on the first post-reset cycle.
- `capture`  out  1  high during the capture window.
- `cur_idx`  out  SEL_W  FF index of the current run.
- `cur_cyc`  out  CYC_W  injection cycle of the current run.
- `done`  out  1  one-cycle pulse per completed run.
- `detected`  out  1  valid with `done`; equals the inverse of `misr_ok`.
- `last`  out  1  valid with `done`; set on the final run of the campaign.

## Operation
- FSM states are IDLE, DRST, RUN, CAPT and REPORT.
- **IDLE**
  - `dut_rst`=1, `eqed_sel`=0.
  - On `start`: load `cur_idx`←`ff_idx` and `cur_cyc`←`inj_cyc`, then go to DRST.
- **DRST** (1 cycle)
  - `dut_rst`=1, `error_injected`←0, `cycle_count`←1.
  - Next state is RUN.
- **RUN**
  - `dut_rst`=0; `cycle_count` increments each cycle, saturating at all-ones.
  - Injection condition: `cycle_count`==`cur_cyc`, `cur_cyc`≠0 and `cur_idx`<N_FF.
  - While the condition holds, `eqed_sel[cur_idx]`=1 for that single cycle and every other bit is 0.
  - At the next edge, `error_injected`←1.
  - RUN→CAPT at the edge ending the cycle where `cycle_count`==`cur_cyc`.
  - If `cur_cyc`==0, RUN→CAPT after the cycle with `cycle_count`==1.
  - If `cycle_count` saturates before reaching `cur_cyc`, go to CAPT anyway with no injection.
- **CAPT**
  - `capture`=1 for exactly WINDOW cycles; `cycle_count` keeps incrementing; `eqed_sel`=0.
  - `misr_ok` is sampled on the last CAPT cycle.
  - Next state is REPORT.
- **REPORT** (1 cycle)
  - `done`=1 and `detected`=¬(sampled `misr_ok`).
  - `dut_rst`=1 (the DUT is held in reset from here on).
  - Then the next run's DRST (sweep mode) or IDLE.
- `error_injected` can be set at most once per run. `eqed_sel` is never non-zero outside RUN.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: `dut_rst`=1; every other output 0; state IDLE.
- `rst` asserted mid-run: next cycle the block is in IDLE with the reset values. No `done` pulse is produced.
- Timeline for a `start` sampled at edge k:
  - DRST during cycle k+1.
  - First RUN cycle at k+2, with `cycle_count`=1.
  - Injection during the RUN cycle where `cycle_count`=`cur_cyc`, i.e. cycle k+1+`cur_cyc`.
  - CAPT cycles k+2+`cur_cyc` through k+1+`cur_cyc`+WINDOW.
  - `done` at cycle k+2+`cur_cyc`+WINDOW.
- Run period is `cur_cyc`+WINDOW+2 cycles, with no idle gap between back-to-back sweep runs.

## Configuration
- `EQED_INJECT_SWEEP_EN` defined:
  - After REPORT, advance `cur_idx`. When it reaches N_FF, wrap it to 0 and increment `cur_cyc`.
  - Stop when `cur_cyc` would exceed `cyc_max`.
  - `last`=1 on the final `done`. If `cyc_max`<`inj_cyc`, exactly one run is made, with `last`=1.
  - If the starting `ff_idx`≥N_FF, the first run is golden and the sweep then continues from index 0.
- Not defined:
  - Single-run mode: every REPORT returns to IDLE with `last`=1.
  - `cyc_max` is unused.

## Test plan
- Single mode, N_FF=8, WINDOW=5, `ff_idx`=5, `inj_cyc`=4, `start` at edge 0 → `eqed_sel`=8'b0010_0000 only during cycle 5 (`cycle_count`=4). `error_injected` rises at cycle 6. `capture` is high cycles 6–10. `done`=1 at cycle 11.
- `ff_idx`=8 (golden run), `inj_cyc`=3 → `eqed_sel` stays 0, `error_injected` stays 0, `done` at cycle 10. With `misr_ok`=1 held, `detected`=0.
- `misr_ok` driven 0 only on the last CAPT cycle → `detected`=1. Driving 0 on any earlier CAPT cycle → `detected`=0.
- Sweep build, `ff_idx`=6, `inj_cyc`=1, `cyc_max`=2 → 10 runs with (idx, cyc) pairs (6,1),(7,1),(0,2)…(7,2). `last` is set only on the 10th `done`; `busy` then falls.
- `rst` pulsed during CAPT → next cycle `busy`=0, `dut_rst`=1, `capture`=0, no `done`. A new `start` runs cleanly.
- `start` pulsed while `busy` → no effect; `cur_idx` and `cur_cyc` are unchanged.
